// File: rtl/bus_arbiter.sv
// bus_arbiter: CPU/DMA round-robin bus arbiter; define BUS_ARBITER_HRAM_BYPASS_EN to let HRAM CPU accesses through dma_lock
module bus_arbiter #(
  parameter logic [15:0] HRAM_LO = 16'hFF80,
  parameter logic [15:0] HRAM_HI = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  input  logic        dma_lock,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_re,
  output logic        bus_we,
  input  logic [7:0]  bus_rdata,
  output logic        grant_dma,
  output logic [15:0] stall_cnt
);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state;
  logic cpu_open, cpu_ok, dma_ok, pick_dma;
  if (HRAM_LO > HRAM_HI) begin : g_bad_window
    $error("bus_arbiter: HRAM_LO above HRAM_HI");
  end
`ifdef BUS_ARBITER_HRAM_BYPASS_EN
  assign cpu_open = !dma_lock || (cpu_addr >= HRAM_LO && cpu_addr <= HRAM_HI);
`else
  assign cpu_open = !dma_lock;
`endif
  assign cpu_ok = cpu_req && !cpu_ack && cpu_open;
  assign dma_ok = dma_req && !dma_ack;
  // grant_dma doubles as the round-robin pointer; a live DMA always beats a lock-bypassing CPU
  assign pick_dma = dma_ok && (!cpu_ok || dma_lock || !grant_dma);
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bus_re    <= 1'b0;
      bus_we    <= 1'b0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      bus_addr  <= 16'h0000;
      bus_wdata <= 8'h00;
      cpu_rdata <= 8'h00;
      dma_rdata <= 8'h00;
      grant_dma <= 1'b0;
      stall_cnt <= 16'h0000;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      if (cpu_req && !cpu_ack && !(state == XFER && !grant_dma) && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (state == IDLE) begin
        if (dma_ok || cpu_ok) begin
          state     <= XFER;
          grant_dma <= pick_dma;
          bus_addr  <= pick_dma ? dma_addr : cpu_addr;
          bus_wdata <= pick_dma ? dma_wdata : cpu_wdata;
          bus_we    <= pick_dma ? dma_we : cpu_we;
          bus_re    <= pick_dma ? !dma_we : !cpu_we;
        end
      end else begin
        state  <= IDLE;
        bus_re <= 1'b0;
        bus_we <= 1'b0;
        if (grant_dma) begin
          dma_ack   <= 1'b1;
          dma_rdata <= bus_rdata;
        end else begin
          cpu_ack   <= 1'b1;
          cpu_rdata <= bus_rdata;
        end
      end
    end
  end
endmodule
